// File: rtl/divide_nonrestoring.sv
// ---------------------------------------------------------------------------
// divide_nonrestoring
//   Sequential non-restoring divider producing one quotient bit per clock.
//   Every add/subtract goes through one shared ripple-carry add/subtract
//   (RCAS) chain: it does the per-step P +/- B during RUN and the final
//   remainder correction P + B during FIX.
//
//   Configuration macro: SIGNED_DIV_EN
//     undefined : A, B, Q, R are unsigned; no sign logic is built.
//     defined   : A, B, Q, R are two's complement. The core divides the
//                 magnitudes and FIX applies the signs (truncating division).
//
// Ports
//   clk   in   1      clock, rising edge
//   rst   in   1      asynchronous active-high reset
//   load  in   1      start strobe, samples A and B on the same edge
//   A     in   WIDTH  dividend
//   B     in   WIDTH  divisor
//   Q     out  WIDTH  quotient (registered)
//   R     out  WIDTH  remainder (registered)
//   busy  out  1      division in progress (RUN or FIX)
//   done  out  1      one-cycle pulse, Q/R valid from this cycle on
//   dz    out  1      divide-by-zero flag, held until next load with B!=0
// ---------------------------------------------------------------------------
module divide_nonrestoring #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             busy,
  output logic             done,
  output logic             dz
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIX
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [WIDTH:0]   r_p;      // signed partial remainder, one bit wider than B
  logic [WIDTH-1:0] r_aq;     // dividend shifting out / quotient shifting in
  logic [WIDTH-1:0] r_b;      // latched divisor (magnitude in signed build)
  logic [CW-1:0]    r_count;

  logic             w_start;
  logic             w_dz_hit;
  logic             w_fix_wr;
  logic             w_b_zero;

  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic [WIDTH-1:0] w_q_fin;
  logic [WIDTH-1:0] w_r_fin;
  logic [WIDTH-1:0] w_rem;

  // -------------------------------------------------------------------------
  // Operand conditioning and result sign application
  // -------------------------------------------------------------------------
`ifdef SIGNED_DIV_EN
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic r_neg_q;
  logic r_neg_r;

  // Magnitude of -2^(WIDTH-1) is 2^(WIDTH-1), which still fits unsigned.
  assign w_a_mag = A[WIDTH-1] ? (~A + ONE) : A;
  assign w_b_mag = B[WIDTH-1] ? (~B + ONE) : B;
  // -2^(WIDTH-1) / -1 falls out naturally: magnitude quotient 2^(WIDTH-1)
  // with no negation is exactly the wrapped value.
  assign w_q_fin = r_neg_q ? (~r_aq + ONE) : r_aq;
  assign w_r_fin = r_neg_r ? (~w_rem + ONE) : w_rem;
`else
  assign w_a_mag = A;
  assign w_b_mag = B;
  assign w_q_fin = r_aq;
  assign w_r_fin = w_rem;
`endif

  assign w_b_zero = (B == '0);

  // -------------------------------------------------------------------------
  // Shared RCAS chain
  //   RUN: operand is {P,Aq} shifted left by one; subtract when P >= 0.
  //   FIX: operand is P itself; always add (used only when P < 0).
  // -------------------------------------------------------------------------
  logic [WIDTH:0] w_p_sh;
  logic [WIDTH:0] w_add_a;
  logic [WIDTH:0] w_add_b;
  logic [WIDTH:0] w_sum;
  logic [WIDTH:0] w_carry;
  logic           w_sub;

  assign w_p_sh  = {r_p[WIDTH-1:0], r_aq[WIDTH-1]};
  assign w_sub   = (r_state == S_RUN) && !r_p[WIDTH];
  assign w_add_a = (r_state == S_RUN) ? w_p_sh : r_p;
  assign w_add_b = {1'b0, r_b} ^ {(WIDTH + 1){w_sub}};
  assign w_carry[0] = w_sub;

  generate
    for (genvar gi = 0; gi <= WIDTH; gi++) begin : g_rcas
      assign w_sum[gi] = w_add_a[gi] ^ w_add_b[gi] ^ w_carry[gi];
      // Carry out of the MSB is discarded: the result always fits in WIDTH+1.
      if (gi < WIDTH) begin : g_carry
        assign w_carry[gi+1] = (w_add_a[gi] & w_add_b[gi]) |
                               (w_carry[gi] & (w_add_a[gi] ^ w_add_b[gi]));
      end
    end
  endgenerate

  // Final remainder: correct a negative partial remainder by adding B back.
  assign w_rem = r_p[WIDTH] ? w_sum[WIDTH-1:0] : r_p[WIDTH-1:0];

  // -------------------------------------------------------------------------
  // FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    w_dz_hit     = 1'b0;
    w_fix_wr     = (r_state == S_FIX);

    case (r_state)
      S_RUN:   if (r_count == CNT_ONE) w_state_next = S_FIX;
      S_FIX:   w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase

    // A load in any state is accepted: it aborts RUN, and in FIX it starts
    // the next operation after the current result has been written.
    if (load) begin
      if (w_b_zero) begin
        w_dz_hit     = 1'b1;
        w_state_next = S_IDLE;
      end else begin
        w_start      = 1'b1;
        w_state_next = S_RUN;
      end
    end
  end

  assign busy = (r_state != S_IDLE);

  // -------------------------------------------------------------------------
  // Datapath and result registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_p     <= '0;
      r_aq    <= '0;
      r_b     <= '0;
      r_count <= '0;
      Q       <= '0;
      R       <= '0;
      done    <= 1'b0;
      dz      <= 1'b0;
`ifdef SIGNED_DIV_EN
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
`endif
    end else begin
      done <= 1'b0;

      if (w_fix_wr) begin
        Q    <= w_q_fin;
        R    <= w_r_fin;
        done <= 1'b1;
      end

      // A divide-by-zero load coinciding with FIX takes precedence on Q/R.
      if (w_dz_hit) begin
        Q    <= '1;
        R    <= A;
        dz   <= 1'b1;
        done <= 1'b1;
      end else if (w_start) begin
        r_p     <= '0;
        r_aq    <= w_a_mag;
        r_b     <= w_b_mag;
        r_count <= CNT_INIT;
        dz      <= 1'b0;
`ifdef SIGNED_DIV_EN
        r_neg_q <= A[WIDTH-1] ^ B[WIDTH-1];
        r_neg_r <= A[WIDTH-1];
`endif
      end else if (r_state == S_RUN) begin
        r_p     <= w_sum;
        r_aq    <= {r_aq[WIDTH-2:0], ~w_sum[WIDTH]};
        r_count <= r_count - CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_divide_nonrestoring.sv
module tb_divide_nonrestoring;

  logic       clk;
  logic       rst;
  logic       load;
  logic [7:0] A;
  logic [7:0] B;
  logic [7:0] Q;
  logic [7:0] R;
  logic       busy;
  logic       done;
  logic       dz;

  int n_checks;
  int n_errors;

  divide_nonrestoring #(.WIDTH(8)) dut (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .A    (A),
    .B    (B),
    .Q    (Q),
    .R    (R),
    .busy (busy),
    .done (done),
    .dz   (dz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  // One complete division: load for one edge, wait for done, check results.
  task automatic run_div(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] q_e, input logic [7:0] r_e, input logic dz_e);
    int edges;
    @(negedge clk);
    A = a; B = b; load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
    if (b == 8'd0) begin
      check({tag, " done_on_load"}, 32'(done), 32'd1);
      check({tag, " busy_on_load"}, 32'(busy), 32'd0);
    end else begin
      edges = 0;
      while (!done && edges < 30) begin
        @(posedge clk); #1;
        edges++;
      end
      check({tag, " latency"}, 32'(edges), 32'd9);
    end
    check({tag, " Q"}, 32'(Q), 32'(q_e));
    check({tag, " R"}, 32'(R), 32'(r_e));
    check({tag, " dz"}, 32'(dz), 32'(dz_e));
    @(posedge clk); #1;
    check({tag, " done_low_after"}, 32'(done), 32'd0);
    check({tag, " busy_low_after"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int edges;
    int n_done;
    int done_edge;
    logic [7:0] q_cap;
    logic [7:0] r_cap;

    n_checks = 0;
    n_errors = 0;
    rst  = 1'b1;
    load = 1'b0;
    A    = 8'd0;
    B    = 8'd0;

    repeat (2) @(posedge clk);
    #1;
    check("reset Q", 32'(Q), 32'd0);
    check("reset R", 32'(R), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset dz", 32'(dz), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_div("100/7", 8'd100, 8'd7, 8'd14, 8'd2, 1'b0);
    run_div("255/1", 8'd255, 8'd1, 8'd255, 8'd0, 1'b0);
    run_div("5/9", 8'd5, 8'd9, 8'd0, 8'd5, 1'b0);
    run_div("0/5", 8'd0, 8'd5, 8'd0, 8'd0, 1'b0);
    run_div("120/11", 8'd120, 8'd11, 8'd10, 8'd10, 1'b0);
    run_div("13/0", 8'd13, 8'd0, 8'hFF, 8'd13, 1'b1);
    run_div("20/4", 8'd20, 8'd4, 8'd5, 8'd0, 1'b0);

    // Asynchronous reset in the middle of RUN, between clock edges.
    @(negedge clk);
    A = 8'd100; B = 8'd7; load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("midrun rst Q", 32'(Q), 32'd0);
    check("midrun rst R", 32'(R), 32'd0);
    check("midrun rst busy", 32'(busy), 32'd0);
    check("midrun rst done", 32'(done), 32'd0);
    check("midrun rst dz", 32'(dz), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_div("after rst 100/7", 8'd100, 8'd7, 8'd14, 8'd2, 1'b0);

    // Abort: second load three cycles after the first; exactly one done.
    @(negedge clk);
    A = 8'd50; B = 8'd5; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (2) @(negedge clk);
    A = 8'd9; B = 8'd2; load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
    n_done = 0; done_edge = 0; q_cap = 8'd0; r_cap = 8'd0;
    for (int i = 1; i <= 15; i++) begin
      @(posedge clk); #1;
      if (done) begin
        n_done++;
        done_edge = i;
        q_cap = Q;
        r_cap = R;
      end
    end
    check("abort done_count", 32'(n_done), 32'd1);
    check("abort latency", 32'(done_edge), 32'd9);
    check("abort Q", 32'(q_cap), 32'd4);
    check("abort R", 32'(r_cap), 32'd1);

    // Load arriving in the FIX cycle: result still delivered, next op starts.
    @(negedge clk);
    A = 8'd100; B = 8'd7; load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    A = 8'd20; B = 8'd4; load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
    check("fixload done", 32'(done), 32'd1);
    check("fixload Q", 32'(Q), 32'd14);
    check("fixload R", 32'(R), 32'd2);
    check("fixload busy", 32'(busy), 32'd1);
    edges = 0;
    @(posedge clk); #1;
    edges++;
    check("fixload done_not_held", 32'(done), 32'd0);
    while (!done && edges < 30) begin
      @(posedge clk); #1;
      edges++;
    end
    check("fixload second latency", 32'(edges), 32'd9);
    check("fixload second Q", 32'(Q), 32'd5);
    check("fixload second R", 32'(R), 32'd0);

`ifdef SIGNED_DIV_EN
    run_div("-100/7", 8'h9C, 8'd7, 8'hF2, 8'hFE, 1'b0);
    run_div("100/-7", 8'd100, 8'hF9, 8'hF2, 8'h02, 1'b0);
    run_div("-128/-1", 8'h80, 8'hFF, 8'h80, 8'h00, 1'b0);
    run_div("-13/0", 8'hF3, 8'd0, 8'hFF, 8'hF3, 1'b1);
`else
    run_div("250/3", 8'd250, 8'd3, 8'd83, 8'd1, 1'b0);
    run_div("200/201", 8'd200, 8'd201, 8'd0, 8'd200, 1'b0);
    run_div("255/255", 8'd255, 8'd255, 8'd1, 8'd0, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
